// File: rtl/ps2_key_decoder_if.sv
// ----------------------------------------------------------------------------
// ps2_key_decoder_if
//   Signal bundle between the board's PS/2 pins, the key decoder and the game
//   logic.
//
//   Signals
//     ps2_clk     PS/2 clock pin (asynchronous to clk)
//     ps2_data    PS/2 data pin (asynchronous to clk)
//     keys_left   {up,down} held state of the left pad
//     keys_right  {up,down} held state of the right pad
//     frame_err   one-clk pulse when a frame is dropped
//     fsm_state   receiver state (debug): 0 IDLE, 1 DATA, 2 PARITY, 3 STOP
//
//   Output protocol: there is no valid/ready handshake. keys_left and
//   keys_right are registered levels that change only when a good frame
//   completes. frame_err is a single-cycle strobe and cannot be
//   back-pressured.
//
//   Modports
//     master  pin side and consumer (drives the pins, observes the outputs)
//     slave   the decoder itself
// ----------------------------------------------------------------------------
interface ps2_key_decoder_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [1:0] keys_left;
    logic [1:0] keys_right;
    logic       frame_err;
    logic [1:0] fsm_state;

    modport master (
        output ps2_clk,
        output ps2_data,
        input  keys_left,
        input  keys_right,
        input  frame_err,
        input  fsm_state
    );

    modport slave (
        input  ps2_clk,
        input  ps2_data,
        output keys_left,
        output keys_right,
        output frame_err,
        output fsm_state
    );
endinterface

// File: rtl/ps2_key_decoder.sv
// ----------------------------------------------------------------------------
// ps2_key_decoder
//   Receives PS/2 keyboard frames (scan code set 2) and turns the make/break
//   codes of four keys into held-state bits for the two game pads.
//   Bit 1 of each pad = "up", bit 0 = "down".
//
//   Ports
//     clk    in  system clock
//     rst_n  in  asynchronous reset, active low
//     bus    ps2_key_decoder_if.slave
//              ps2_clk/ps2_data in, keys_left/keys_right/frame_err out,
//              fsm_state out (debug view of the receiver state)
//
//   Parameters
//     TIMEOUT_CYCLES  clk cycles without a ps2_clk falling edge mid-frame
//                     before the partial frame is abandoned
//     KEY_L_UP/KEY_L_DN  left pad codes (non-extended)
//     KEY_R_UP/KEY_R_DN  right pad codes (E0-extended)
//
//   Configuration macro
//     PS2_PARITY_CHECK_EN  when defined, a frame with even parity is dropped
//                          and reported on frame_err; otherwise the parity
//                          bit is ignored.
// ----------------------------------------------------------------------------
module ps2_key_decoder #(
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter logic [7:0]  KEY_L_UP       = 8'h1D,
    parameter logic [7:0]  KEY_L_DN       = 8'h1B,
    parameter logic [7:0]  KEY_R_UP       = 8'h75,
    parameter logic [7:0]  KEY_R_DN       = 8'h72
) (
    input logic                clk,
    input logic                rst_n,
    ps2_key_decoder_if.slave   bus
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    // ---------------- pin synchronizers and edge detect ----------------
    // Reset to 1 (the idle level of both lines) so that releasing reset can
    // never look like a falling edge.
    logic ps2_clk_meta, ps2_clk_sync, ps2_clk_prev;
    logic ps2_data_meta, ps2_data_sync;
    logic clk_fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ps2_clk_meta  <= 1'b1;
            ps2_clk_sync  <= 1'b1;
            ps2_clk_prev  <= 1'b1;
            ps2_data_meta <= 1'b1;
            ps2_data_sync <= 1'b1;
        end else begin
            ps2_clk_meta  <= bus.ps2_clk;
            ps2_clk_sync  <= ps2_clk_meta;
            ps2_clk_prev  <= ps2_clk_sync;
            ps2_data_meta <= bus.ps2_data;
            ps2_data_sync <= ps2_data_meta;
        end
    end

    assign clk_fall = ps2_clk_prev & ~ps2_clk_sync;

    // ---------------- receiver state ----------------
    state_t           state;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift_reg;
    logic [CNT_W-1:0] timeout_cnt;
    logic             ext_flag;
    logic             brk_flag;
    logic [1:0]       keys_left_q;
    logic [1:0]       keys_right_q;
    logic             frame_err_q;
    logic             frame_ok;

`ifdef PS2_PARITY_CHECK_EN
    logic parity_bit;

    // Sampled stop bit must be 1 and the data+parity must have odd weight.
    assign frame_ok = ps2_data_sync & (^{shift_reg, parity_bit});
`else
    assign frame_ok = ps2_data_sync;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            bit_cnt      <= 3'd0;
            shift_reg    <= 8'h00;
            timeout_cnt  <= '0;
            ext_flag     <= 1'b0;
            brk_flag     <= 1'b0;
            keys_left_q  <= 2'b00;
            keys_right_q <= 2'b00;
            frame_err_q  <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
            parity_bit   <= 1'b0;
`endif
        end else begin
            frame_err_q <= 1'b0;

            if (clk_fall) begin
                timeout_cnt <= '0;
                case (state)
                    ST_IDLE: begin
                        if (!ps2_data_sync) begin
                            state   <= ST_DATA;
                            bit_cnt <= 3'd0;
                        end else begin
                            // A high "start bit" means we are out of step
                            // with the keyboard.
                            frame_err_q <= 1'b1;
                        end
                    end

                    ST_DATA: begin
                        // LSB arrives first, so shift in from the top.
                        shift_reg <= {ps2_data_sync, shift_reg[7:1]};
                        bit_cnt   <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= ST_PARITY;
                        end
                    end

                    ST_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
                        parity_bit <= ps2_data_sync;
`endif
                        state <= ST_STOP;
                    end

                    ST_STOP: begin
                        state <= ST_IDLE;
                        if (!frame_ok) begin
                            // Dropped byte: prefix flags survive so a
                            // retransmitted code still sees them.
                            frame_err_q <= 1'b1;
                        end else if (shift_reg == 8'hE0) begin
                            ext_flag <= 1'b1;
                        end else if (shift_reg == 8'hF0) begin
                            brk_flag <= 1'b1;
                        end else begin
                            // Key bit follows make (set) / break (clear);
                            // matching includes the E0 prefix exactly.
                            if (!ext_flag && shift_reg == KEY_L_UP) keys_left_q[1]  <= ~brk_flag;
                            if (!ext_flag && shift_reg == KEY_L_DN) keys_left_q[0]  <= ~brk_flag;
                            if ( ext_flag && shift_reg == KEY_R_UP) keys_right_q[1] <= ~brk_flag;
                            if ( ext_flag && shift_reg == KEY_R_DN) keys_right_q[0] <= ~brk_flag;
                            ext_flag <= 1'b0;
                            brk_flag <= 1'b0;
                        end
                    end

                    default: state <= ST_IDLE;
                endcase
            end else if (state != ST_IDLE) begin
                if (timeout_cnt == CNT_LAST) begin
                    // Keyboard stalled mid-frame: abandon the partial byte.
                    state       <= ST_IDLE;
                    bit_cnt     <= 3'd0;
                    shift_reg   <= 8'h00;
                    timeout_cnt <= '0;
                    frame_err_q <= 1'b1;
                end else begin
                    timeout_cnt <= timeout_cnt + 1'b1;
                end
            end
        end
    end

    assign bus.keys_left  = keys_left_q;
    assign bus.keys_right = keys_right_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.fsm_state  = state;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// ----------------------------------------------------------------------------
// tb_ps2_key_decoder
//   Directed bench for ps2_key_decoder. Frames are bit-banged onto the pins
//   with a 16-clk PS/2 bit period; the timeout is shortened to keep runs short.
// ----------------------------------------------------------------------------
module tb_ps2_key_decoder;

    localparam int unsigned TO_CYCLES = 200;

`ifdef PS2_PARITY_CHECK_EN
    localparam logic [1:0] KL_AFTER_BAD_PAR  = 2'b00;
    localparam int         ERR_FROM_BAD_PAR  = 1;
`else
    localparam logic [1:0] KL_AFTER_BAD_PAR  = 2'b10;
    localparam int         ERR_FROM_BAD_PAR  = 0;
`endif

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ps2_key_decoder_if bus ();

    ps2_key_decoder #(
        .TIMEOUT_CYCLES (TO_CYCLES)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_errors = 0;
    int err_seen = 0;
    logic [3:0] exp_q[$];
    logic [1:0] lat_kl2;
    logic [1:0] lat_kl3;

    // Count every frame_err strobe seen by the game side.
    always @(negedge clk) begin
        if (bus.frame_err === 1'b1) err_seen++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic send_bit(input logic b);
        bus.ps2_data = b;
        repeat (4) @(negedge clk);
        bus.ps2_clk = 1'b0;
        repeat (8) @(negedge clk);
        bus.ps2_clk = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // Full frame; the stop-bit edge also captures keys_left 2 and 3 clk
    // after the pin falls.
    task automatic send_frame(input logic [7:0] b, input logic par_flip, input logic stop_bit);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit((~^b) ^ par_flip);
        bus.ps2_data = stop_bit;
        repeat (4) @(negedge clk);
        bus.ps2_clk = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        lat_kl2 = bus.keys_left;
        @(posedge clk);
        @(negedge clk);
        lat_kl3 = bus.keys_left;
        repeat (5) @(negedge clk);
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic frame_check(input string tag, input logic [7:0] b,
                               input logic [1:0] exp_kl, input logic [1:0] exp_kr);
        logic [3:0] exp_v;
        send_frame(b, 1'b0, 1'b1);
        exp_q.push_back({exp_kl, exp_kr});
        exp_v = exp_q.pop_front();
        check(tag, {28'd0, bus.keys_left, bus.keys_right}, {28'd0, exp_v});
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int err0;
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        rst_n        = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_keys_left",  {30'd0, bus.keys_left},  32'd0);
        check("rst_keys_right", {30'd0, bus.keys_right}, 32'd0);
        check("rst_frame_err",  {31'd0, bus.frame_err},  32'd0);
        check("rst_state",      {30'd0, bus.fsm_state},  32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // 1: W make, with exact latency
        send_frame(8'h1D, 1'b0, 1'b1);
        check("lat_2clk_kl", {30'd0, lat_kl2}, 32'h0);
        check("lat_3clk_kl", {30'd0, lat_kl3}, 32'h2);
        check("w_make_kr",   {30'd0, bus.keys_right}, 32'h0);
        check("w_make_err",  err_seen, 0);

        // 2: break prefix alone, then release W
        frame_check("f0_alone", 8'hF0, 2'b10, 2'b00);
        frame_check("w_break",  8'h1D, 2'b00, 2'b00);

        // 3: extended arrows, keypad 8 without E0, W with E0
        frame_check("e0_a",      8'hE0, 2'b00, 2'b00);
        frame_check("up_make",   8'h75, 2'b00, 2'b10);
        frame_check("e0_b",      8'hE0, 2'b00, 2'b10);
        frame_check("dn_make",   8'h72, 2'b00, 2'b11);
        frame_check("e0_c",      8'hE0, 2'b00, 2'b11);
        frame_check("f0_c",      8'hF0, 2'b00, 2'b11);
        frame_check("up_break",  8'h75, 2'b00, 2'b01);
        frame_check("kp8_bare",  8'h75, 2'b00, 2'b01);
        frame_check("e0_d",      8'hE0, 2'b00, 2'b01);
        frame_check("w_ext",     8'h1D, 2'b00, 2'b01);
        check("ext_err", err_seen, 0);

        // 4: bad stop bit, then good S
        err0 = err_seen;
        send_frame(8'h1B, 1'b0, 1'b0);
        check("bad_stop_err", err_seen - err0, 1);
        check("bad_stop_kl",  {30'd0, bus.keys_left}, 32'h0);
        frame_check("s_make", 8'h1B, 2'b01, 2'b01);
        frame_check("s_repeat", 8'h1B, 2'b01, 2'b01);

        // start bit high while idle
        err0 = err_seen;
        send_bit(1'b1);
        check("bad_start_err",   err_seen - err0, 1);
        check("bad_start_state", {30'd0, bus.fsm_state}, 32'd0);

        // 5: partial frame then stall
        err0 = err_seen;
        for (int i = 0; i < 5; i++) send_bit((i == 0) ? 1'b0 : 1'b1);
        check("partial_state", {30'd0, bus.fsm_state}, 32'd1);
        repeat (TO_CYCLES + 20) @(negedge clk);
        check("timeout_err",   err_seen - err0, 1);
        check("timeout_state", {30'd0, bus.fsm_state}, 32'd0);
        frame_check("w_after_to", 8'h1D, 2'b11, 2'b01);

        // release both left keys
        frame_check("f0_d",     8'hF0, 2'b11, 2'b01);
        frame_check("w_brk2",   8'h1D, 2'b01, 2'b01);
        frame_check("f0_e",     8'hF0, 2'b01, 2'b01);
        frame_check("s_brk",    8'h1B, 2'b00, 2'b01);

        // 6: W with wrong parity
        err0 = err_seen;
        send_frame(8'h1D, 1'b1, 1'b1);
        check("bad_par_kl",  {30'd0, bus.keys_left}, {30'd0, KL_AFTER_BAD_PAR});
        check("bad_par_err", err_seen - err0, ERR_FROM_BAD_PAR);

        // reset mid-frame
        for (int i = 0; i < 3; i++) send_bit(1'b0);
        rst_n = 1'b0;
        #1;
        check("midrst_kl",    {30'd0, bus.keys_left},  32'd0);
        check("midrst_kr",    {30'd0, bus.keys_right}, 32'd0);
        check("midrst_err",   {31'd0, bus.frame_err},  32'd0);
        check("midrst_state", {30'd0, bus.fsm_state},  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        frame_check("s_after_rst", 8'h1B, 2'b01, 2'b00);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Hard bound so the run always ends.
    initial begin
        #3000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
